// File: rtl/icache_assoc_fetch2.sv
// icache_assoc_fetch2: set-associative, physically-tagged instruction cache
// with tree-PLRU replacement, an index-invalidate op and an uncached path.
// Stage 1 reads tag/data RAMs; stage 2 compares tags and selects data.
// Optional macro ICACHE_PERF_EN enables the saturating hit/miss counters.
module icache_assoc_fetch2 #(
  parameter int LINE_WORD_NUM = 8,
  parameter int ASSOC_NUM     = 2,
  parameter int SET_NUM       = 128,
  parameter int FETCH_WORDS   = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cpu_valid,
  input  logic [31:0]                   cpu_addr,
  input  logic                          cpu_cached,
  input  logic                          cpu_inv,
  input  logic                          cpu_stall,
  output logic                          cpu_busy,
  output logic [32*FETCH_WORDS-1:0]     cpu_rdata,
  output logic [FETCH_WORDS-1:0]        cpu_rmask,
  output logic                          axi_rd_req,
  output logic [31:0]                   axi_rd_addr,
  input  logic                          axi_rd_rdy,
  input  logic                          axi_ret_valid,
  input  logic [32*LINE_WORD_NUM-1:0]   axi_ret_data,
  output logic                          axi_urd_req,
  output logic [31:0]                   axi_urd_addr,
  input  logic                          axi_urd_rdy,
  input  logic                          axi_uret_valid,
  input  logic [31:0]                   axi_uret_data,
  output logic [31:0]                   perf_hit_cnt,
  output logic [31:0]                   perf_miss_cnt
);

  localparam int WO_W   = $clog2(LINE_WORD_NUM);
  localparam int OFF_W  = WO_W + 2;
  localparam int IDX_W  = $clog2(SET_NUM);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LVL    = $clog2(ASSOC_NUM);
  localparam int WAY_W  = (LVL > 0) ? LVL : 1;
  localparam int PLRU_W = (ASSOC_NUM > 1) ? ASSOC_NUM - 1 : 1;
  localparam int LINE_W = 32 * LINE_WORD_NUM;

  typedef enum logic [2:0] {
    S_LOOKUP, S_INV, S_MISS_REQ, S_MISS_WAIT,
    S_REFILL_WR, S_UNC_REQ, S_UNC_WAIT, S_UNC_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  // Storage: tag/data RAMs (no reset), valid and PLRU flops (reset)
  logic [TAG_W-1:0]   r_tag_ram  [SET_NUM][ASSOC_NUM];
  logic [LINE_W-1:0]  r_data_ram [SET_NUM][ASSOC_NUM];
  logic [ASSOC_NUM-1:0] r_valid  [SET_NUM];
  logic [PLRU_W-1:0]  r_plru     [SET_NUM];

  // Stage-1 RAM outputs
  logic [TAG_W-1:0]   r_tag_rd  [ASSOC_NUM];
  logic [LINE_W-1:0]  r_data_rd [ASSOC_NUM];

  // Stage-2 request
  logic        r_req_valid;
  logic [31:0] r_req_addr;
  logic        r_req_cached;
  logic        r_req_inv;
  logic [31:0] r_unc_data;

  logic [IDX_W-1:0]     w_req_idx, w_cpu_idx, w_rd_idx;
  logic [TAG_W-1:0]     w_req_tag;
  logic [WO_W-1:0]      w_req_wo;
  logic                 w_ram_en;
  logic [ASSOC_NUM-1:0] w_hit_vec;
  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_way, w_victim;
  logic                 w_refill;
  logic [LINE_W-1:0]    w_line;
  logic [31:0]          w_words [LINE_WORD_NUM];

  // Heap-ordered tree: node n uses bit n-1; a 0 bit points the victim left.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int unsigned node;
    logic [PLRU_W-1:0] sh;
    node = 1;
    for (int unsigned l = 0; l < LVL; l++) begin
      sh   = bits >> (node - 1);
      node = 2 * node + 32'(sh[0]);
    end
    return WAY_W'(node - ASSOC_NUM);
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0] way);
    int unsigned node;
    logic [WAY_W-1:0]  sw;
    logic [PLRU_W-1:0] res;
    res  = bits;
    node = 1;
    for (int unsigned l = 0; l < LVL; l++) begin
      sw   = way >> (LVL - 1 - l);
      res  = (res & ~(PLRU_W'(1) << (node - 1))) | (PLRU_W'(~sw[0]) << (node - 1));
      node = 2 * node + 32'(sw[0]);
    end
    return res;
  endfunction

  assign w_req_idx = r_req_addr[OFF_W +: IDX_W];
  assign w_req_tag = r_req_addr[31 -: TAG_W];
  assign w_req_wo  = r_req_addr[2 +: WO_W];
  assign w_cpu_idx = cpu_addr[OFF_W +: IDX_W];
  assign w_rd_idx  = (r_state == S_MISS_REQ || r_state == S_MISS_WAIT ||
                      r_state == S_REFILL_WR) ? w_req_idx : w_cpu_idx;
  assign w_ram_en  = ~cpu_stall | (r_state == S_REFILL_WR);
  assign w_refill  = (r_state == S_MISS_WAIT) & axi_ret_valid;
  assign w_victim  = plru_victim(r_plru[w_req_idx]);
  assign w_hit     = |w_hit_vec;

  // Stage-2 request register: load when not stalled, drop an invalidate once done
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_req_valid  <= 1'b0;
      r_req_addr   <= '0;
      r_req_cached <= 1'b0;
      r_req_inv    <= 1'b0;
    end else if (!cpu_stall) begin
      r_req_valid  <= cpu_valid;
      r_req_addr   <= cpu_addr;
      r_req_cached <= cpu_cached;
      r_req_inv    <= cpu_inv;
    end else if (r_state == S_INV) begin
      r_req_valid  <= 1'b0;
    end
  end

  // Stage-1 synchronous RAM read and refill write
  always_ff @(posedge clk) begin
    if (w_ram_en) begin
      for (int unsigned w = 0; w < ASSOC_NUM; w++) begin
        r_tag_rd[w]  <= r_tag_ram[w_rd_idx][w];
        r_data_rd[w] <= r_data_ram[w_rd_idx][w];
      end
    end
    if (w_refill) begin
      r_tag_ram[w_req_idx][w_victim]  <= w_req_tag;
      r_data_ram[w_req_idx][w_victim] <= axi_ret_data;
    end
  end

  // Valid bits and PLRU state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned s = 0; s < SET_NUM; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if (r_state == S_INV)
        r_valid[w_req_idx] <= '0;
      if (w_refill) begin
        r_valid[w_req_idx][w_victim] <= 1'b1;
        r_plru[w_req_idx] <= plru_touch(r_plru[w_req_idx], w_victim);
      end else if (w_hit && !cpu_stall) begin
        r_plru[w_req_idx] <= plru_touch(r_plru[w_req_idx], w_hit_way);
      end
    end
  end

  // Tag compare; hits count only in LOOKUP so stale RAM outputs never look like a hit
  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < ASSOC_NUM; w++) begin
      w_hit_vec[w] = (r_state == S_LOOKUP) & r_req_valid & r_req_cached & ~r_req_inv &
                     r_valid[w_req_idx][w] & (r_tag_rd[w] == w_req_tag);
      if (w_hit_vec[w])
        w_hit_way = WAY_W'(w);
    end
  end

  // Hit-way line select and split into words
  always_comb begin
    w_line = '0;
    for (int unsigned w = 0; w < ASSOC_NUM; w++)
      if (w_hit_vec[w])
        w_line = w_line | r_data_rd[w];
    for (int unsigned i = 0; i < LINE_WORD_NUM; i++)
      w_words[i] = w_line[32*i +: 32];
  end

  // CPU-side data, mask and busy
  always_comb begin
    cpu_rdata = '0;
    cpu_rmask = '0;
    if (w_hit) begin
      cpu_rdata[31:0] = w_words[w_req_wo];
      if (FETCH_WORDS == 2 && w_req_wo != '1) begin
        cpu_rdata[32*FETCH_WORDS-1 -: 32] = w_words[w_req_wo + WO_W'(1)];
        cpu_rmask = '1;
      end else begin
        cpu_rmask = FETCH_WORDS'(1);
      end
    end else if (r_state == S_UNC_DONE && r_req_valid) begin
      cpu_rdata[31:0] = r_unc_data;
      cpu_rmask = FETCH_WORDS'(1);
    end
    cpu_busy = r_req_valid & ((r_req_cached & ~r_req_inv & ~w_hit) |
                              (~r_req_cached & (r_state != S_UNC_DONE)) |
                              (r_req_inv & (r_state != S_INV)));
  end

  // Uncached return word latch
  always_ff @(posedge clk) begin
    if (!resetn)
      r_unc_data <= '0;
    else if (r_state == S_UNC_WAIT && axi_uret_valid)
      r_unc_data <= axi_uret_data;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn)
      r_state <= S_LOOKUP;
    else
      r_state <= w_state_nxt;
  end

  // FSM next state and bus requests
  always_comb begin
    w_state_nxt  = r_state;
    axi_rd_req   = 1'b0;
    axi_rd_addr  = '0;
    axi_urd_req  = 1'b0;
    axi_urd_addr = '0;
    case (r_state)
      S_LOOKUP: begin
        if (r_req_valid) begin
          if (r_req_inv)          w_state_nxt = S_INV;
          else if (!r_req_cached) w_state_nxt = S_UNC_REQ;
          else if (!w_hit)        w_state_nxt = S_MISS_REQ;
        end
      end
      S_INV:       w_state_nxt = S_LOOKUP;
      S_MISS_REQ: begin
        axi_rd_req  = 1'b1;
        axi_rd_addr = {w_req_tag, w_req_idx, {OFF_W{1'b0}}};
        if (axi_rd_rdy) w_state_nxt = S_MISS_WAIT;
      end
      S_MISS_WAIT: if (axi_ret_valid) w_state_nxt = S_REFILL_WR;
      S_REFILL_WR: w_state_nxt = S_LOOKUP;
      S_UNC_REQ: begin
        axi_urd_req  = 1'b1;
        axi_urd_addr = r_req_addr;
        if (axi_urd_rdy) w_state_nxt = S_UNC_WAIT;
      end
      S_UNC_WAIT:  if (axi_uret_valid) w_state_nxt = S_UNC_DONE;
      S_UNC_DONE:  if (!cpu_stall) w_state_nxt = S_LOOKUP;
      default:     w_state_nxt = S_LOOKUP;
    endcase
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_perf_hit, r_perf_miss;

  // Saturating hit/miss counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_perf_hit  <= '0;
      r_perf_miss <= '0;
    end else begin
      if (w_hit && !cpu_stall && r_perf_hit != '1)
        r_perf_hit <= r_perf_hit + 32'd1;
      if (r_state == S_LOOKUP && w_state_nxt == S_MISS_REQ && r_perf_miss != '1)
        r_perf_miss <= r_perf_miss + 32'd1;
    end
  end

  assign perf_hit_cnt  = r_perf_hit;
  assign perf_miss_cnt = r_perf_miss;
`else
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_assoc_fetch2.sv
// Directed bench for icache_assoc_fetch2: a table of fetches with
// hand-computed results, then invalidate, reset-mid-refill and uncached
// stall-hold sequences.
module tb_icache_assoc_fetch2;

  logic         clk = 1'b0;
  logic         resetn;
  logic         cpu_valid, cpu_cached, cpu_inv, cpu_stall, cpu_busy;
  logic [31:0]  cpu_addr;
  logic [63:0]  cpu_rdata;
  logic [1:0]   cpu_rmask;
  logic         axi_rd_req, axi_rd_rdy, axi_ret_valid;
  logic [31:0]  axi_rd_addr;
  logic [255:0] axi_ret_data;
  logic         axi_urd_req, axi_urd_rdy, axi_uret_valid;
  logic [31:0]  axi_urd_addr, axi_uret_data;
  logic [31:0]  perf_hit_cnt, perf_miss_cnt;
  logic         tb_hold;

  int n_checks = 0;
  int n_pass   = 0;

  assign cpu_stall = cpu_busy | tb_hold;

  icache_assoc_fetch2 #(
    .LINE_WORD_NUM(8), .ASSOC_NUM(2), .SET_NUM(128), .FETCH_WORDS(2)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_cached(cpu_cached),
    .cpu_inv(cpu_inv), .cpu_stall(cpu_stall), .cpu_busy(cpu_busy),
    .cpu_rdata(cpu_rdata), .cpu_rmask(cpu_rmask),
    .axi_rd_req(axi_rd_req), .axi_rd_addr(axi_rd_addr), .axi_rd_rdy(axi_rd_rdy),
    .axi_ret_valid(axi_ret_valid), .axi_ret_data(axi_ret_data),
    .axi_urd_req(axi_urd_req), .axi_urd_addr(axi_urd_addr), .axi_urd_rdy(axi_urd_rdy),
    .axi_uret_valid(axi_uret_valid), .axi_uret_data(axi_uret_data),
    .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        miss;
    logic [31:0] rd_addr;
    logic [63:0] rdata;
    logic [1:0]  rmask;
  } vec_t;

  vec_t vecs [13];

  // Memory image: word i of the line at address a
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] ln;
    for (int i = 0; i < 8; i++)
      ln[32*i +: 32] = 32'h90 + ((a >> 12) << 4) + (((a >> 5) & 32'h7f) << 8) + 32'(i);
    return ln;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic issue(input logic [31:0] a, input logic cached, input logic inv);
    cpu_valid  = 1'b1;
    cpu_addr   = a;
    cpu_cached = cached;
    cpu_inv    = inv;
  endtask

  // Serves refill/uncached handshakes until the request stops being busy
  task automatic complete(output logic first_busy, output logic saw_rd,
                          output logic [31:0] rd_addr, output logic saw_urd,
                          output logic [31:0] urd_addr);
    logic rd_pend, urd_pend;
    logic [31:0] la;
    rd_pend = 1'b0; urd_pend = 1'b0; la = '0;
    saw_rd = 1'b0; saw_urd = 1'b0; rd_addr = '0; urd_addr = '0;
    @(negedge clk);
    cpu_valid = 1'b0;
    cpu_inv   = 1'b0;
    first_busy = cpu_busy;
    for (int n = 0; n < 60 && cpu_busy; n++) begin
      axi_rd_rdy = 1'b0; axi_ret_valid = 1'b0; axi_urd_rdy = 1'b0; axi_uret_valid = 1'b0;
      if (rd_pend) begin
        axi_ret_valid = 1'b1; axi_ret_data = line_of(la); rd_pend = 1'b0;
      end else if (axi_rd_req) begin
        saw_rd = 1'b1; la = axi_rd_addr; rd_addr = la; axi_rd_rdy = 1'b1; rd_pend = 1'b1;
      end
      if (urd_pend) begin
        axi_uret_valid = 1'b1; urd_pend = 1'b0;
      end else if (axi_urd_req) begin
        saw_urd = 1'b1; urd_addr = axi_urd_addr; axi_urd_rdy = 1'b1; urd_pend = 1'b1;
      end
      @(negedge clk);
    end
    axi_rd_rdy = 1'b0; axi_ret_valid = 1'b0; axi_urd_rdy = 1'b0; axi_uret_valid = 1'b0;
    check("fetch done (busy)", {63'b0, cpu_busy}, 64'd0);
  endtask

  initial begin
    logic fb, srd, surd;
    logic [31:0] ra, ua;

    vecs[0]  = '{32'h1000, 1'b1, 32'h1000, 64'h000000A1_000000A0, 2'b11};
    vecs[1]  = '{32'h101C, 1'b0, 32'h0,    64'h00000000_000000A7, 2'b01};
    vecs[2]  = '{32'h1008, 1'b0, 32'h0,    64'h000000A3_000000A2, 2'b11};
    vecs[3]  = '{32'h2000, 1'b1, 32'h2000, 64'h000000B1_000000B0, 2'b11};
    vecs[4]  = '{32'h1000, 1'b0, 32'h0,    64'h000000A1_000000A0, 2'b11};
    vecs[5]  = '{32'h3000, 1'b1, 32'h3000, 64'h000000C1_000000C0, 2'b11};
    vecs[6]  = '{32'h1004, 1'b0, 32'h0,    64'h000000A2_000000A1, 2'b11};
    vecs[7]  = '{32'h2000, 1'b1, 32'h2000, 64'h000000B1_000000B0, 2'b11};
    vecs[8]  = '{32'h3018, 1'b1, 32'h3000, 64'h000000C7_000000C6, 2'b11};
    vecs[9]  = '{32'h1020, 1'b1, 32'h1020, 64'h000001A1_000001A0, 2'b11};
    vecs[10] = '{32'h2004, 1'b0, 32'h0,    64'h000000B2_000000B1, 2'b11};
    vecs[11] = '{32'h1000, 1'b1, 32'h1000, 64'h000000A1_000000A0, 2'b11};
    vecs[12] = '{32'h100C, 1'b0, 32'h0,    64'h000000A4_000000A3, 2'b11};

    resetn = 1'b0; tb_hold = 1'b0;
    cpu_valid = 1'b0; cpu_addr = '0; cpu_cached = 1'b0; cpu_inv = 1'b0;
    axi_rd_rdy = 1'b0; axi_ret_valid = 1'b0; axi_ret_data = '0;
    axi_urd_rdy = 1'b0; axi_uret_valid = 1'b0; axi_uret_data = 32'h3C08BFC0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    check("reset busy",  {63'b0, cpu_busy}, 64'd0);
    check("reset rdata", cpu_rdata, 64'd0);
    check("reset rmask", {62'b0, cpu_rmask}, 64'd0);
    check("reset rd_req", {63'b0, axi_rd_req}, 64'd0);
    check("reset urd_req", {63'b0, axi_urd_req}, 64'd0);
    check("reset perf_hit", {32'b0, perf_hit_cnt}, 64'd0);
    check("reset perf_miss", {32'b0, perf_miss_cnt}, 64'd0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      issue(vecs[i].addr, 1'b1, 1'b0);
      complete(fb, srd, ra, surd, ua);
      check($sformatf("vec%0d miss", i), {63'b0, srd}, {63'b0, vecs[i].miss});
      if (vecs[i].miss)
        check($sformatf("vec%0d rd_addr", i), {32'b0, ra}, {32'b0, vecs[i].rd_addr});
      else
        check($sformatf("vec%0d hit latency busy", i), {63'b0, fb}, 64'd0);
      check($sformatf("vec%0d rdata", i), cpu_rdata, vecs[i].rdata);
      check($sformatf("vec%0d rmask", i), {62'b0, cpu_rmask}, {62'b0, vecs[i].rmask});
    end

    // Invalidate 0x1000, then fetch the same index in the very next cycle
    @(negedge clk);
    issue(32'h1000, 1'b1, 1'b1);
    complete(fb, srd, ra, surd, ua);
    check("inv rmask", {62'b0, cpu_rmask}, 64'd0);
    check("inv no refill", {63'b0, srd}, 64'd0);
    issue(32'h1000, 1'b1, 1'b0);
    complete(fb, srd, ra, surd, ua);
    check("after inv miss", {63'b0, srd}, 64'd1);
    check("after inv rdata", cpu_rdata, 64'h000000A1_000000A0);

    // Reset while waiting for a refill line, with a late return alongside
    @(negedge clk);
    issue(32'h5000, 1'b1, 1'b0);
    @(negedge clk);
    cpu_valid = 1'b0;
    for (int n = 0; n < 20 && !axi_rd_req; n++) @(negedge clk);
    check("rst-seq rd_req", {63'b0, axi_rd_req}, 64'd1);
    axi_rd_rdy = 1'b1;
    @(negedge clk);
    axi_rd_rdy = 1'b0;
    resetn = 1'b0;
    axi_ret_valid = 1'b1; axi_ret_data = line_of(32'h5000);
    @(negedge clk);
    axi_ret_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("rst-seq busy", {63'b0, cpu_busy}, 64'd0);
    check("rst-seq rd_req low", {63'b0, axi_rd_req}, 64'd0);
    check("rst-seq rmask", {62'b0, cpu_rmask}, 64'd0);
    @(negedge clk);
    issue(32'h1000, 1'b1, 1'b0);
    complete(fb, srd, ra, surd, ua);
    check("post-reset miss", {63'b0, srd}, 64'd1);
    check("post-reset rd_addr", {32'b0, ra}, 64'h1000);
    check("post-reset rdata", cpu_rdata, 64'h000000A1_000000A0);
`ifdef ICACHE_PERF_EN
    check("perf_miss after reset", {32'b0, perf_miss_cnt}, 64'd1);
`else
    check("perf_miss tied", {32'b0, perf_miss_cnt}, 64'd0);
    check("perf_hit tied", {32'b0, perf_hit_cnt}, 64'd0);
`endif

    // Uncached fetch, result held for 3 stalled cycles
    @(negedge clk);
    issue(32'h1FC0_0000, 1'b0, 1'b0);
    complete(fb, srd, ra, surd, ua);
    tb_hold = 1'b1;
    check("unc no refill", {63'b0, srd}, 64'd0);
    check("unc urd_addr", {32'b0, ua}, 64'h1FC0_0000);
    check("unc rdata", cpu_rdata, 64'h00000000_3C08BFC0);
    check("unc rmask", {62'b0, cpu_rmask}, 64'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("unc hold%0d rdata", k), cpu_rdata, 64'h00000000_3C08BFC0);
      check($sformatf("unc hold%0d rmask", k), {62'b0, cpu_rmask}, 64'd1);
      check($sformatf("unc hold%0d busy", k), {63'b0, cpu_busy}, 64'd0);
    end
    tb_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("unc released rmask", {62'b0, cpu_rmask}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
